// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and transmitter.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} rx_state_t;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_MIN_CPB   = 4;

endpackage

// File: rtl/uart_sync.sv
// N-flop synchronizer for asynchronous inputs; powers up high so an idle-high line never
// looks like a start bit after reset.
module uart_sync
  import uart_pkg::*;
#(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic [N-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '1;
    else     r_sync <= {r_sync[N-2:0], i_async};
  end

  assign o_sync = r_sync[N-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with run-time bit period, valid/read handshake, framing-error pulse
// and sticky overrun flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int SYNC_FF   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          clock_per_bit,
  input  logic                 rx_i,
  input  logic                 rx_read_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 rx_done_tick_o,
  output logic                 frame_err_o,
  output logic                 overrun_o
);

  rx_state_t            r_state;
  rx_state_t            w_state_nxt;
  logic [15:0]          r_cpb;
  logic [15:0]          r_timer;
  logic [2:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shreg;
  logic                 w_rxs;
  logic                 w_start_smp;
  logic                 w_bit_end;
  logic                 w_data_smp;
  logic                 w_commit;
  logic                 w_ferr;

  uart_sync #(.N(SYNC_FF)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (rx_i),
    .o_sync  (w_rxs)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (!w_rxs) w_state_nxt = START;
      START:   if (w_start_smp) w_state_nxt = w_rxs ? IDLE : DATA;
      DATA:    if (w_bit_end && (r_bit_cnt == 3'(DATA_BITS - 1))) w_state_nxt = STOP;
      STOP:    if (w_bit_end) w_state_nxt = w_rxs ? IDLE : RECOVER;
      RECOVER: if (w_rxs) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_start_smp = (r_state == START) && (r_timer == ((r_cpb >> 1) - 16'd1));
    w_bit_end   = (r_timer == (r_cpb - 16'd1));
    w_data_smp  = (r_state == DATA) && w_bit_end;
    w_commit    = (r_state == STOP) && w_bit_end && w_rxs;
    w_ferr      = (r_state == STOP) && w_bit_end && !w_rxs;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_cpb          <= '0;
      r_timer        <= '0;
      r_bit_cnt      <= '0;
      r_shreg        <= '0;
      rx_data_o      <= '0;
      rx_valid_o     <= 1'b0;
      rx_done_tick_o <= 1'b0;
      frame_err_o    <= 1'b0;
      overrun_o      <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      rx_done_tick_o <= w_commit;
      frame_err_o    <= w_ferr;

      if ((r_state == IDLE) && (w_state_nxt == START)) r_cpb <= clock_per_bit;

      if ((w_state_nxt != r_state) || (r_state == IDLE) || (r_state == RECOVER) || w_bit_end)
        r_timer <= '0;
      else
        r_timer <= r_timer + 16'd1;

      if (w_data_smp) begin
        r_shreg   <= {w_rxs, r_shreg[DATA_BITS-1:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end

      // A commit in the same cycle as a read keeps the new byte valid.
      if (w_commit) begin
        rx_data_o  <= r_shreg;
        rx_valid_o <= 1'b1;
        if (rx_valid_o && !rx_read_i) overrun_o <= 1'b1;
      end else if (rx_read_i) begin
        rx_valid_o <= 1'b0;
        overrun_o  <= 1'b0;
      end
    end
  end

endmodule
